// File: rtl/fetch_redirect_unit.sv
// fetch_redirect_unit
//   Program-counter and instruction-fetch front end. Issues sequential
//   fetches (one outstanding request), buffers one instruction for decode,
//   and on a redirect discards stale in-flight responses and pulses flush.
//
// State table:
//   state  | meaning
//   IDLE   | just out of reset, no fetch issued yet
//   REQ    | presenting a fetch request for pc
//   WAIT   | one request outstanding, waiting for imem_rvalid
//
// Ports:
//   clk, rst            clock, async active-high reset
//   jumpEnable/Target   redirect from branch control
//   stall               decode not accepting the buffered instruction
//   imem_req/addr       fetch request to instruction memory
//   imem_ready          request accepted this cycle
//   imem_rvalid/rdata   instruction memory response (never backpressured)
//   instr_valid/instr/instr_pc  buffered instruction for decode
//   flush               one-cycle kill pulse for younger stages
module fetch_redirect_unit #(
  parameter int                ADDR_W   = 32,
  parameter int                INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               jumpEnable,
  input  logic [ADDR_W-1:0]  jumpTarget,
  input  logic               stall,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ready,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               flush
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] req_pc;
  logic [ADDR_W-1:0] jump_pc;
  logic              drop;
  logic              fire;
  logic              load;

  // Redirect targets are word aligned; the low bits are simply cleared.
  assign jump_pc   = jumpTarget & ~ADDR_W'(3);
  assign imem_addr = pc;
  assign fire      = imem_req && imem_ready;
  // A response is only kept if it was not marked stale and no redirect
  // lands on the same edge.
  assign load      = (state == S_WAIT) && imem_rvalid && !drop && !jumpEnable;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    imem_req = 1'b0;
    case (state)
      S_IDLE: state_nx = S_REQ;
      S_REQ: begin
        // Only issue when the returning instruction has somewhere to land.
        imem_req = !instr_valid || !stall;
        if (imem_req && imem_ready) state_nx = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid) state_nx = S_REQ;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      req_pc      <= '0;
      drop        <= 1'b0;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
      flush       <= 1'b0;
    end else begin
      flush <= jumpEnable;

      if (jumpEnable)  pc <= jump_pc;
      else if (fire)   pc <= pc + ADDR_W'(4);

      if (fire) req_pc <= pc;

      case (state)
        // A request accepted on a redirect edge is already stale.
        S_REQ:   if (fire) drop <= jumpEnable;
        S_WAIT: begin
          if (imem_rvalid)     drop <= 1'b0;
          else if (jumpEnable) drop <= 1'b1;
        end
        default: drop <= 1'b0;
      endcase

      if (jumpEnable) begin
        instr_valid <= 1'b0;
      end else if (load) begin
        instr_valid <= 1'b1;
        instr       <= imem_rdata;
        instr_pc    <= req_pc;
      end else if (instr_valid && !stall) begin
        instr_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/fetch_redirect_unit.md
Name: fetch_redirect_unit

Overview:
- Program-counter and instruction-fetch front end.
- Consumes the redirect produced by branch control (jumpEnable, target pc) and issues sequential fetches to instruction memory, with one outstanding request.
- Buffers one fetched instruction for decode.
- On a redirect, discards stale in-flight responses and pulses a flush to the younger pipeline stages.

Parameters:
- ADDR_W, 32, instruction address width; matches the instruction address path.
- INSTR_W, 32, instruction word width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- jumpEnable  in  1  redirect request from branch control.
- jumpTarget  in  ADDR_W  redirect target pc.
- stall  in  1  decode not accepting the buffered instruction.
- imem_req  out  1  fetch request valid.
- imem_addr  out  ADDR_W  fetch address.
- imem_ready  in  1  request accepted this cycle when imem_req=1.
- imem_rvalid  in  1  response valid.
- imem_rdata  in  INSTR_W  response instruction.
- instr_valid  out  1  output buffer holds an instruction.
- instr  out  INSTR_W  buffered instruction.
- instr_pc  out  ADDR_W  pc of the buffered instruction.
- flush  out  1  one-cycle kill pulse for younger stages.

Behaviour:
- Reset (async, immediate):
  - pc=RESET_PC, state=IDLE, drop=0.
  - instr_valid=0, instr=0, instr_pc=0, flush=0, imem_req=0, imem_addr=RESET_PC.
- State machine:
  - IDLE: imem_req=0; go to REQ on the first edge after rst deasserts.
  - REQ: imem_req=(!instr_valid || !stall), imem_addr=pc (combinational from the pc register).
    - On imem_req && imem_ready: req_pc<=pc, pc<=pc+4, go to WAIT.
    - Otherwise stay in REQ.
  - WAIT: imem_req=0.
    - On imem_rvalid with drop=0: instr<=imem_rdata, instr_pc<=req_pc, instr_valid<=1, go to REQ.
    - On imem_rvalid with drop=1: discard the response, drop<=0, go to REQ.
- Buffer:
  - Consumed on an edge where instr_valid && !stall; instr_valid<=0 unless refilled the same edge.
  - Held unchanged while stall=1.
  - The issue rule guarantees the buffer is empty or being consumed whenever a response can arrive.
  - imem_rvalid is never backpressured.
- Only one request is outstanding. imem_rvalid outside WAIT is ignored.
- Redirect (jumpEnable=1 on an edge) has priority over all other updates:
  - pc<=jumpTarget with bits [1:0] forced to 0; the sequential pc+4 is suppressed.
  - instr_valid<=0 regardless of stall.
  - flush<=1 for exactly the next cycle; back-to-back redirects hold flush high.
  - In WAIT without rvalid: drop<=1, stay in WAIT.
  - In WAIT with rvalid the same cycle: response discarded, go to REQ.
  - In REQ with imem_req && imem_ready the same cycle: the request becomes outstanding, drop<=1, go to WAIT, pc<=target.
  - In REQ without acceptance: stay in REQ; the next request uses the target.
  - In IDLE: pc<=target, go to REQ.
- Arithmetic: pc+4 wraps modulo 2^ADDR_W (32'hFFFF_FFFC -> 0), no error.
- Reset mid-operation: all state cleared, including drop. A response for a pre-reset request that arrives while in IDLE or REQ is ignored. The memory side must not return it after a new request is accepted.
- Latency: request accepted in cycle N, rvalid in cycle N+k gives instr_valid high from cycle N+k+1. Minimum turnaround is back-to-back requests every 2 cycles when memory responds in 1 cycle.

Test Plan:
1. Reset release, imem_ready=1, rvalid one cycle after each accept, stall=0 -> imem_addr sequence 0x0,0x4,0x8; instr_pc matches each; instr equals rdata.
2. stall=1 with a buffered instruction at pc 0x4 -> instr_valid, instr, instr_pc held; imem_req=0 until stall drops; then the next request is at 0x8.
3. jumpEnable with jumpTarget=0x103 while in WAIT, rvalid two cycles later -> flush high for one cycle; that response dropped (instr_valid stays 0); next imem_addr=0x100.
4. jumpEnable in the same cycle as imem_req&&imem_ready at pc 0x20, target 0x80 -> the response to 0x20 is discarded; next request is 0x80, not 0x24.
5. Initialise RESET_PC=32'hFFFF_FFFC; fetch twice -> second imem_addr=0x0.
6. Assert rst while in WAIT, release, then deliver a late rvalid in REQ before any accept -> ignored; outputs remain at reset values; fetch restarts at RESET_PC.
